// File: rtl/qpsk_rx_frame_ctrl_if.sv
// Byte stream from the QPSK frame controller to the deframer (valid/ready with frame markers).
interface qpsk_rx_frame_ctrl_if;
   logic [7:0] byte_o;
   logic       byte_valid;
   logic       byte_ready;
   logic       frame_start;
   logic       frame_end;

   modport master (output byte_o, byte_valid, frame_start, frame_end, input byte_ready);
   modport slave  (input byte_o, byte_valid, frame_start, frame_end, output byte_ready);
endinterface

// File: rtl/qpsk_rx_frame_ctrl.sv
// QPSK receive sequencer: decimates I/Q to the slicer, hunts the sync byte, packs payload bytes.
// Optional: define QPSK_CTRL_SYNC_INV_EN to also lock on the inverted sync word (180 deg ambiguity).
module qpsk_rx_frame_ctrl #(
   parameter int         SPS       = 8,
   parameter int         FRAME_LEN = 16,
   parameter logic [7:0] SYNC_WORD = 8'hB8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(SPS)-1:0]  sample_phase,
   input  logic                    in_valid,
   input  logic signed [15:0]      in_i,
   input  logic signed [15:0]      in_q,
   output logic signed [15:0]      slc_i,
   output logic signed [15:0]      slc_q,
   input  logic [1:0]              slc_sym,
   qpsk_rx_frame_ctrl_if.master    byte_if,
   output logic                    locked,
   output logic                    overflow
);
   localparam int              PW         = $clog2(SPS);
   localparam logic [PW-1:0]   PH_MAX     = PW'(SPS - 1);
   localparam logic [7:0]      LAST_IDX   = 8'(FRAME_LEN - 1);
   localparam logic [0:0]      ST_HUNT    = 1'b0;
   localparam logic [0:0]      ST_PAYLOAD = 1'b1;

   logic [PW-1:0] phase_eff;
   logic [PW-1:0] cnt_reg;
   logic          strobe;
   logic [1:0]    sym_pipe_reg;
   logic          sym_ev;
   logic [1:0]    sym_eff;
   logic [0:0]    state_reg;
   logic [7:0]    sh_reg;
   logic [7:0]    sh_shift;
   logic [1:0]    sib_reg;
   logic [7:0]    byte_cnt_reg;
   logic          sync_hit;
   logic          byte_done;
   logic          last_byte;
   logic          out_busy;
   logic [7:0]    byte_reg;
   logic          valid_reg;
   logic          start_reg;
   logic          end_reg;
   logic          overflow_reg;

   // Out-of-range phase settings clamp to the last sample of the symbol.
   assign phase_eff = (32'(sample_phase) >= SPS) ? PH_MAX : sample_phase;
   assign strobe    = in_valid && (cnt_reg == phase_eff);
   assign sym_ev    = sym_pipe_reg[1];

`ifdef QPSK_CTRL_SYNC_INV_EN
   logic inv_reg;
   logic sync_inv_hit;
   assign sym_eff      = slc_sym ^ {2{inv_reg}};
   assign sync_inv_hit = (sh_shift == ~SYNC_WORD);
`else
   assign sym_eff = slc_sym;
`endif

   assign sh_shift  = {sh_reg[5:0], sym_eff};
   assign sync_hit  = (sh_shift == SYNC_WORD);
   assign last_byte = (byte_cnt_reg == LAST_IDX);
   assign byte_done = sym_ev && (state_reg == ST_PAYLOAD) && (sib_reg == 2'd3);
   assign out_busy  = valid_reg && !byte_if.byte_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg      <= '0;
         slc_i        <= '0;
         slc_q        <= '0;
         sym_pipe_reg <= '0;
      end else begin
         if (in_valid)
            cnt_reg <= (cnt_reg == PH_MAX) ? '0 : cnt_reg + 1'b1;
         if (strobe) begin
            slc_i <= in_i;
            slc_q <= in_q;
         end
         // The slicer registers its decision, so the symbol is ready two clocks after the strobe.
         sym_pipe_reg <= {sym_pipe_reg[0], strobe};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_HUNT;
         sh_reg       <= '0;
         sib_reg      <= '0;
         byte_cnt_reg <= '0;
`ifdef QPSK_CTRL_SYNC_INV_EN
         inv_reg      <= 1'b0;
`endif
      end else if (sym_ev) begin
         case (state_reg)
            ST_HUNT: begin
               sh_reg <= sh_shift;
               if (sync_hit) begin
                  state_reg    <= ST_PAYLOAD;
                  sib_reg      <= '0;
                  byte_cnt_reg <= '0;
               end
`ifdef QPSK_CTRL_SYNC_INV_EN
               else if (sync_inv_hit) begin
                  state_reg    <= ST_PAYLOAD;
                  sib_reg      <= '0;
                  byte_cnt_reg <= '0;
                  inv_reg      <= 1'b1;
               end
`endif
            end
            ST_PAYLOAD: begin
               sh_reg  <= sh_shift;
               sib_reg <= sib_reg + 2'd1;
               if (sib_reg == 2'd3) begin
                  if (last_byte) begin
                     state_reg    <= ST_HUNT;
                     sh_reg       <= '0;
                     byte_cnt_reg <= '0;
`ifdef QPSK_CTRL_SYNC_INV_EN
                     inv_reg      <= 1'b0;
`endif
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + 8'd1;
                  end
               end
            end
            default: state_reg <= ST_HUNT;
         endcase
      end
   end

   // A byte completing while the previous one is still stalled is dropped; the frame count still advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_reg     <= '0;
         valid_reg    <= 1'b0;
         start_reg    <= 1'b0;
         end_reg      <= 1'b0;
         overflow_reg <= 1'b0;
      end else if (byte_done && !out_busy) begin
         byte_reg  <= sh_shift;
         valid_reg <= 1'b1;
         start_reg <= (byte_cnt_reg == 8'd0);
         end_reg   <= last_byte;
      end else begin
         if (byte_done)
            overflow_reg <= 1'b1;
         if (valid_reg && byte_if.byte_ready)
            valid_reg <= 1'b0;
      end
   end

   assign byte_if.byte_o      = byte_reg;
   assign byte_if.byte_valid  = valid_reg;
   assign byte_if.frame_start = start_reg;
   assign byte_if.frame_end   = end_reg;
   assign locked              = (state_reg == ST_PAYLOAD);
   assign overflow            = overflow_reg;
endmodule
